// File: rtl/bsg_axil_rd_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite read slave among num_masters_p read masters.
// Optional watchdog and SLVERR completion enabled by defining BSG_AXIL_RD_ARB_TIMEOUT_EN.
module bsg_axil_rd_arbiter #(
  parameter int num_masters_p = 2,
  parameter int timeout_p     = 1024
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [num_masters_p-1:0][31:0]         araddr_i,
  input  logic [num_masters_p-1:0]               arvalid_i,
  output logic [num_masters_p-1:0]               arready_o,
  output logic [31:0]                            rdata_o,
  output logic [1:0]                             rresp_o,
  output logic [num_masters_p-1:0]               rvalid_o,
  input  logic [num_masters_p-1:0]               rready_i,
  output logic [31:0]                            m_araddr_o,
  output logic                                   m_arvalid_o,
  input  logic                                   m_arready_i,
  input  logic [31:0]                            m_rdata_i,
  input  logic [1:0]                             m_rresp_i,
  input  logic                                   m_rvalid_i,
  output logic                                   m_rready_o,
  output logic [$clog2(num_masters_p)-1:0]       grant_o,
  output logic                                   busy_o
);

  localparam int lg_masters_lp = $clog2(num_masters_p);

  typedef logic [lg_masters_lp-1:0] idx_t;
  typedef logic [lg_masters_lp:0]   wide_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  idx_t        last_q,  last_d;
  idx_t        grant_q, grant_d;
  logic [31:0] addr_q,  addr_d;

  idx_t        pick;
  logic        any_req;

  assign any_req = |arvalid_i;

  // Round-robin search starting one past the last master served, wrapping at num_masters_p.
  always_comb begin : rr_pick
    wide_t sum;
    logic  found;
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    pick  = grant_q;
    found = 1'b0;
    sum   = '0;
    for (int i = 1; i <= num_masters_p; i++) begin
      sum = {1'b0, last_q} + wide_t'(i);
      if (sum >= wide_t'(num_masters_p)) begin
        sum = sum - wide_t'(num_masters_p);
      end
      if (!found && arvalid_i[idx_t'(sum)]) begin
        pick  = idx_t'(sum);
        found = 1'b1;
      end
    end
  end

`ifdef BSG_AXIL_RD_ARB_TIMEOUT_EN
  localparam int cnt_w_lp = $clog2(timeout_p) + 1;
  typedef logic [cnt_w_lp-1:0] cnt_t;

  cnt_t cnt_q, cnt_d;
  logic timeout_hit;

  assign timeout_hit = (cnt_q == cnt_t'(timeout_p - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (timeout_p > 0);
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    arready_o   = '0;
    rvalid_o    = '0;
    rdata_o     = '0;
    rresp_o     = '0;
    m_araddr_o  = '0;
    m_arvalid_o = 1'b0;
    m_rready_o  = 1'b0;
    grant_o     = grant_q;

    case (state_q)
      IDLE: begin
        // Sink any stray slave response while no transaction is outstanding.
        m_rready_o = 1'b1;
        grant_o    = pick;
        if (any_req) begin
          arready_o[pick] = 1'b1;
          addr_d          = araddr_i[pick];
          grant_d         = pick;
          state_d         = ADDR;
        end
      end

      ADDR: begin
        m_arvalid_o = 1'b1;
        m_araddr_o  = addr_q;
        if (m_arready_i) begin
          state_d = DATA;
        end
      end

      DATA: begin
        rvalid_o[grant_q] = m_rvalid_i;
        rdata_o           = m_rdata_i;
        rresp_o           = m_rresp_i;
        m_rready_o        = rready_i[grant_q];
        if (m_rvalid_i && rready_i[grant_q]) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end

`ifdef BSG_AXIL_RD_ARB_TIMEOUT_EN
      ERR: begin
        rvalid_o[grant_q] = 1'b1;
        rdata_o           = {16'hDEAD, addr_q[15:0]};
        rresp_o           = 2'b10;
        m_rready_o        = 1'b1;
        if (rready_i[grant_q]) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef BSG_AXIL_RD_ARB_TIMEOUT_EN
    // A completed handshake in the same cycle wins over the watchdog.
    if ((state_q == ADDR || state_q == DATA) && state_d != IDLE && timeout_hit) begin
      state_d = ERR;
    end
`endif
  end

`ifdef BSG_AXIL_RD_ARB_TIMEOUT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && state_d == ADDR) begin
      cnt_d = '0;
    end else if (state_q == ADDR || state_q == DATA) begin
      cnt_d = cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign busy_o = (state_q != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      last_q  <= idx_t'(num_masters_p - 1);
      grant_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_bsg_axil_rd_arbiter.sv
// Directed, table-driven bench for bsg_axil_rd_arbiter (two masters).
// Watchdog/SLVERR sequence runs only when BSG_AXIL_RD_ARB_TIMEOUT_EN is defined.
module tb_bsg_axil_rd_arbiter;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0][31:0] araddr;
  logic [1:0]       arvalid;
  logic [1:0]       arready;
  logic [31:0]      rdata;
  logic [1:0]       rresp;
  logic [1:0]       rvalid;
  logic [1:0]       rready;
  logic [31:0]      m_araddr;
  logic             m_arvalid;
  logic             m_arready;
  logic [31:0]      m_rdata;
  logic [1:0]       m_rresp;
  logic             m_rvalid;
  logic             m_rready;
  logic             grant;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsg_axil_rd_arbiter #(.num_masters_p(2), .timeout_p(16)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
    .m_araddr_o(m_araddr), .m_arvalid_o(m_arvalid), .m_arready_i(m_arready),
    .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rvalid_i(m_rvalid), .m_rready_o(m_rready),
    .grant_o(grant), .busy_o(busy)
  );

  typedef struct {
    logic [1:0]  arvalid;
    logic [1:0]  rready;
    logic        m_arready;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic [1:0]  x_arready;
    logic [1:0]  x_rvalid;
    logic [31:0] x_rdata;
    logic [1:0]  x_rresp;
    logic        x_m_arvalid;
    logic [31:0] x_m_araddr;
    logic        x_m_rready;
    logic        x_grant;
    logic        x_busy;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well away from posedge.
  task automatic drive(input logic [1:0] arv, input logic [1:0] rr, input logic marr,
                       input logic mrv, input logic [31:0] mrd, input logic [1:0] mrr);
    @(negedge clk);
    arvalid   = arv;
    rready    = rr;
    m_arready = marr;
    m_rvalid  = mrv;
    m_rdata   = mrd;
    m_rresp   = mrr;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] arr, input logic [1:0] rv,
                            input logic [31:0] rd, input logic [1:0] rs, input logic mav,
                            input logic [31:0] maa, input logic mrr, input logic g,
                            input logic b);
    check($sformatf("%s arready", tag),   32'(arready),   32'(arr));
    check($sformatf("%s rvalid", tag),    32'(rvalid),    32'(rv));
    check($sformatf("%s rdata", tag),     rdata,          rd);
    check($sformatf("%s rresp", tag),     32'(rresp),     32'(rs));
    check($sformatf("%s m_arvalid", tag), 32'(m_arvalid), 32'(mav));
    check($sformatf("%s m_araddr", tag),  m_araddr,       maa);
    check($sformatf("%s m_rready", tag),  32'(m_rready),  32'(mrr));
    check($sformatf("%s grant", tag),     32'(grant),     32'(g));
    check($sformatf("%s busy", tag),      32'(busy),      32'(b));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Contention from reset, alternation, DECERR, ADDR stall, single request,
    // stray IDLE response and master-side R backpressure, as one cycle-by-cycle trace.
    vecs[0]  = '{2'b11, 2'b11, 1'b0, 1'b0, 32'h0,         2'b00, 2'b01, 2'b00, 32'h0,         2'b00, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0};
    vecs[1]  = '{2'b11, 2'b11, 1'b1, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         2'b00, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{2'b11, 2'b11, 1'b0, 1'b1, 32'h1111_1111, 2'b00, 2'b00, 2'b01, 32'h1111_1111, 2'b00, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1};
    vecs[3]  = '{2'b11, 2'b11, 1'b0, 1'b0, 32'h0,         2'b00, 2'b10, 2'b00, 32'h0,         2'b00, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0};
    vecs[4]  = '{2'b11, 2'b11, 1'b1, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         2'b00, 1'b1, 32'h2000, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{2'b11, 2'b11, 1'b0, 1'b1, 32'h2222_2222, 2'b00, 2'b00, 2'b10, 32'h2222_2222, 2'b00, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1};
    vecs[6]  = '{2'b11, 2'b11, 1'b0, 1'b0, 32'h0,         2'b00, 2'b01, 2'b00, 32'h0,         2'b00, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0};
    vecs[7]  = '{2'b11, 2'b11, 1'b1, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         2'b00, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{2'b11, 2'b11, 1'b0, 1'b1, 32'h0,         2'b11, 2'b00, 2'b01, 32'h0,         2'b11, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1};
    vecs[9]  = '{2'b11, 2'b11, 1'b0, 1'b0, 32'h0,         2'b00, 2'b10, 2'b00, 32'h0,         2'b00, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0};
    vecs[10] = '{2'b11, 2'b11, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         2'b00, 1'b1, 32'h2000, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{2'b11, 2'b11, 1'b1, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         2'b00, 1'b1, 32'h2000, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{2'b11, 2'b11, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         2'b00, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1};
    vecs[13] = '{2'b11, 2'b11, 1'b0, 1'b1, 32'hCAFE_F00D, 2'b00, 2'b00, 2'b10, 32'hCAFE_F00D, 2'b00, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1};
    vecs[14] = '{2'b01, 2'b11, 1'b0, 1'b0, 32'h0,         2'b00, 2'b01, 2'b00, 32'h0,         2'b00, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0};
    vecs[15] = '{2'b00, 2'b11, 1'b1, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         2'b00, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{2'b00, 2'b11, 1'b0, 1'b1, 32'hCAFE_F00D, 2'b00, 2'b00, 2'b01, 32'hCAFE_F00D, 2'b00, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1};
    vecs[17] = '{2'b00, 2'b11, 1'b0, 1'b1, 32'h1234_5678, 2'b00, 2'b00, 2'b00, 32'h0,         2'b00, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0};
    vecs[18] = '{2'b10, 2'b11, 1'b0, 1'b0, 32'h0,         2'b00, 2'b10, 2'b00, 32'h0,         2'b00, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0};
    vecs[19] = '{2'b00, 2'b11, 1'b1, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         2'b00, 1'b1, 32'h2000, 1'b0, 1'b1, 1'b1};
    vecs[20] = '{2'b00, 2'b01, 1'b0, 1'b1, 32'hA5A5_A5A5, 2'b01, 2'b00, 2'b10, 32'hA5A5_A5A5, 2'b01, 1'b0, 32'h0,    1'b0, 1'b1, 1'b1};
    vecs[21] = '{2'b00, 2'b11, 1'b0, 1'b1, 32'hA5A5_A5A5, 2'b01, 2'b00, 2'b10, 32'hA5A5_A5A5, 2'b01, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1};
    vecs[22] = '{2'b00, 2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         2'b00, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0};

    araddr[0] = 32'h0000_1000;
    araddr[1] = 32'h0000_2000;
    reset_n   = 1'b0;
    arvalid   = '0;
    rready    = '0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rresp   = '0;

    drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
    expect_out("reset", 2'b00, 2'b00, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].arvalid, vecs[i].rready, vecs[i].m_arready, vecs[i].m_rvalid,
            vecs[i].m_rdata, vecs[i].m_rresp);
      expect_out($sformatf("v%0d", i), vecs[i].x_arready, vecs[i].x_rvalid, vecs[i].x_rdata,
                 vecs[i].x_rresp, vecs[i].x_m_arvalid, vecs[i].x_m_araddr,
                 vecs[i].x_m_rready, vecs[i].x_grant, vecs[i].x_busy);
    end

    // Backpressure: slave stalls AR for 5 cycles, master stalls R for 4; m1 waits throughout.
    drive(2'b01, 2'b11, 1'b0, 1'b0, 32'h0, 2'b00);
    expect_out("bp accept", 2'b01, 2'b00, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(2'b10, 2'b11, 1'b0, 1'b0, 32'h0, 2'b00);
      expect_out($sformatf("bp ar stall %0d", i), 2'b00, 2'b00, 32'h0, 2'b00, 1'b1,
                 32'h1000, 1'b0, 1'b0, 1'b1);
    end
    drive(2'b10, 2'b11, 1'b1, 1'b0, 32'h0, 2'b00);
    expect_out("bp ar done", 2'b00, 2'b00, 32'h0, 2'b00, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 2'b10, 1'b0, 1'b1, 32'hBEEF_0001, 2'b00);
      expect_out($sformatf("bp r stall %0d", i), 2'b00, 2'b01, 32'hBEEF_0001, 2'b00, 1'b0,
                 32'h0, 1'b0, 1'b0, 1'b1);
    end
    drive(2'b10, 2'b11, 1'b0, 1'b1, 32'hBEEF_0001, 2'b00);
    expect_out("bp r done", 2'b00, 2'b01, 32'hBEEF_0001, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    drive(2'b10, 2'b11, 1'b0, 1'b0, 32'h0, 2'b00);
    expect_out("bp next grant", 2'b10, 2'b00, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    drive(2'b00, 2'b11, 1'b1, 1'b0, 32'h0, 2'b00);
    expect_out("bp m1 addr", 2'b00, 2'b00, 32'h0, 2'b00, 1'b1, 32'h2000, 1'b0, 1'b1, 1'b1);
    drive(2'b00, 2'b11, 1'b0, 1'b1, 32'hBEEF_0002, 2'b00);
    expect_out("bp m1 data", 2'b00, 2'b10, 32'hBEEF_0002, 2'b00, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Asynchronous reset while DATA is waiting on the master.
    drive(2'b01, 2'b11, 1'b0, 1'b0, 32'h0, 2'b00);
    expect_out("rst accept", 2'b01, 2'b00, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(2'b00, 2'b11, 1'b1, 1'b0, 32'h0, 2'b00);
    expect_out("rst addr", 2'b00, 2'b00, 32'h0, 2'b00, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b1);
    drive(2'b00, 2'b00, 1'b0, 1'b1, 32'h55AA_55AA, 2'b00);
    expect_out("rst data", 2'b00, 2'b01, 32'h55AA_55AA, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    expect_out("rst asserted", 2'b00, 2'b00, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(2'b00, 2'b11, 1'b0, 1'b0, 32'h0, 2'b00);
    reset_n = 1'b1;
    drive(2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 2'b00);
    expect_out("post rst accept", 2'b01, 2'b00, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(2'b00, 2'b11, 1'b1, 1'b0, 32'h0, 2'b00);
    expect_out("post rst addr", 2'b00, 2'b00, 32'h0, 2'b00, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b1);
    drive(2'b00, 2'b11, 1'b0, 1'b1, 32'h600D_F00D, 2'b00);
    expect_out("post rst data", 2'b00, 2'b01, 32'h600D_F00D, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

`ifdef BSG_AXIL_RD_ARB_TIMEOUT_EN
    // Slave never answers: ERR appears 16 cycles after ADDR entry, then a late response is sunk.
    drive(2'b01, 2'b11, 1'b0, 1'b0, 32'h0, 2'b00);
    expect_out("to accept", 2'b01, 2'b00, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(2'b00, 2'b11, 1'b1, 1'b0, 32'h0, 2'b00);
    expect_out("to addr", 2'b00, 2'b00, 32'h0, 2'b00, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      drive(2'b00, 2'b11, 1'b0, 1'b0, 32'h0, 2'b00);
      expect_out($sformatf("to wait %0d", i), 2'b00, 2'b00, 32'h0, 2'b00, 1'b0, 32'h0,
                 1'b1, 1'b0, 1'b1);
    end
    drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
    expect_out("to err hold", 2'b00, 2'b01, 32'hDEAD_1000, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    drive(2'b00, 2'b01, 1'b0, 1'b0, 32'h0, 2'b00);
    expect_out("to err done", 2'b00, 2'b01, 32'hDEAD_1000, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    drive(2'b00, 2'b11, 1'b0, 1'b1, 32'hBAD0_BAD0, 2'b00);
    expect_out("to late rvalid", 2'b00, 2'b00, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
